rp_8bit_fetch: RTL and testbench
================================

# rp_8bit_fetch

Instruction fetch sequencer for the rp_8bit core. It issues word reads to program memory and buffers the returned words in a 2-entry prefetch queue. It assembles one- and two-word AVR instructions and hands them to the decoder over a valid/ready handshake. It also applies the control-flow redirects (jump/branch/call/return) and skip requests (cpse/sbrc/sbrs/sbic/sbis) coming back from execute.

## Interface
- `PAW`, default 11: program address width in 16-bit words.
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `bus_req`  out  1  program memory read request.
- `bus_adr`  out  PAW  program memory word address.
- `bus_ack`  in  1  read acknowledge; data is valid on `bus_rdt` in the ack cycle.
- `bus_rdt`  in  16  read data.
- `ins_vld`  out  1  complete instruction available.
- `ins_rdy`  in  1  decoder accepts the instruction.
- `ins_op`  out  32  instruction; `[15:0]` is the first word, `[31:16]` is the second word (zero when `ins_len`=0).
- `ins_pc`  out  PAW  word address of the first word.
- `ins_len`  out  1  0 = one-word instruction, 1 = two-word instruction.
- `jmp_vld`  in  1  redirect request, single-cycle pulse.
- `jmp_adr`  in  PAW  redirect target.
- `skp`  in  1  discard the next complete instruction, single-cycle pulse.
- `hlt`  in  1  stop issuing new reads (sleep/break).

## Operation
- Internal state:
  - fetch pointer `fpc`
  - 2-entry queue of {word, address}
  - outstanding flag (at most one read in flight)
  - drop flag
  - skip-pending flag
- Read issue: a new request is raised when all of the following hold:
  - `hlt`=0
  - no read is outstanding, or the outstanding read is acked this cycle
  - queue entries + outstanding < 2 after this cycle's pop
- Bus handshake:
  - `bus_adr`=`fpc`; `fpc` increments modulo 2^PAW on each ack.
  - Once asserted, `bus_req` and `bus_adr` hold stable until `bus_ack`.
- Acked data is pushed to the queue unless the drop flag is set. If the drop flag is set, the data is discarded and the flag cleared.
- Long-instruction detect on the queue head word:
  - `1001_00??_????_0000` (lds/sts)
  - `1001_010?_????_11??` (jmp/call)
- Instruction completion:
  - A long instruction is complete only when both queue entries are present.
  - A short instruction is complete with the head alone.
- Output: `ins_vld`=complete AND skip-pending=0.
- Pop:
  - On `ins_vld`&`ins_rdy`, pop 1 or 2 entries per `ins_len`.
  - With skip-pending=1, a complete instruction is popped silently (1 or 2 words) and skip-pending clears.
- Redirect (`jmp_vld`=1):
  - Flush the queue, clear skip-pending, set `fpc`=`jmp_adr`.
  - If a read is outstanding and not acked this cycle, set the drop flag.
  - `jmp_vld` has priority over `skp`, `ins_rdy`, and acks in the same cycle; data acked in the same cycle is discarded.
- `skp` sets skip-pending. A `skp` in the same cycle as an accepted transfer applies to the following instruction.
- `hlt` blocks new requests only. An in-flight read completes and queued instructions are still delivered.

## Timing
- Reset values: `bus_req`=0, `bus_adr`=0, `ins_vld`=0, `ins_op`=0, `ins_pc`=0, `ins_len`=0; internal flags cleared, `fpc`=0.
- First `bus_req` is raised in the first cycle after `rst` deasserts.
- Zero-wait memory (ack in the request cycle): data is in the queue at the next edge, and `ins_vld` for a short instruction rises one cycle after the ack.
- Redirect in cycle N: `bus_req` with `bus_adr`=`jmp_adr` in cycle N+1 (or one cycle after the ack of a dropped read); earliest `ins_vld` in N+2.
- All outputs are registered except `ins_vld`/`ins_op`/`ins_pc`/`ins_len`, which are decoded from queue state registers (no path from `ins_rdy`).
- Sustained zero-wait throughput is one short instruction per cycle, and one long instruction per two cycles.
- Wrap-around: address 2^PAW-1 is followed by address 0. A long instruction whose second word wraps is assembled normally.

## Configuration
- `RP_8BIT_FETCH_LONG_EN` defined: two-word detect is active, as described above.
- `RP_8BIT_FETCH_LONG_EN` undefined (reduced cores): every word is a one-word instruction; `ins_len`=0 and `ins_op[31:16]`=0 always.

## Test plan
- Reset release with zero-wait memory holding 0x0000, 0xE0F5, 0x9503: words delivered in order with `ins_pc`=0,1,2 and `ins_len`=0; `ins_vld` first high in cycle 2.
- Memory holds 0x9100, 0x0123 at addresses 4 and 5 (lds), with `RP_8BIT_FETCH_LONG_EN` defined: a single transfer with `ins_op`=0x01239100, `ins_len`=1, `ins_pc`=4. With the macro undefined: two transfers.
- `jmp_vld` with `jmp_adr`=0x100 while a 3-wait-state read of address 7 is outstanding: address-7 data is discarded, the next `bus_adr`=0x100 follows its ack, and the first delivered `ins_pc`=0x100.
- `skp` pulse before a two-word call at address 10: the call is never presented; the next `ins_pc`=12.
- `ins_rdy`=0 for 10 cycles: at most 2 queue entries plus no further requests (`bus_req`=0 once full); no word is lost when `ins_rdy` returns.
- `PAW`=4 with `jmp_adr`=15: the fetch sequence is 15, 0, 1; `ins_pc` wraps to 0.

Source files
------------

// File: rtl/rp_8bit_fetch.sv
// rp_8bit_fetch -- instruction fetch sequencer for the rp_8bit core.
//
// Issues single-word reads to program memory (at most one in flight),
// buffers returned words in a 2-entry prefetch queue, assembles one- and
// two-word instructions and hands them to the decoder on a valid/ready
// handshake. Applies redirects (jmp_vld) and skip requests (skp) from execute.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   bus_req/bus_adr   program memory read request / word address (registered)
//   bus_ack/bus_rdt   read acknowledge / data (valid in the ack cycle)
//   ins_vld/ins_rdy   instruction handshake to the decoder
//   ins_op/ins_pc     instruction words {second, first} / address of first word
//   ins_len           0 = one-word, 1 = two-word instruction
//   jmp_vld/jmp_adr   redirect pulse / target
//   skp               discard the next complete instruction
//   hlt               stop issuing new reads
//
// Configuration: define RP_8BIT_FETCH_LONG_EN to enable two-word
// instruction detection (lds/sts/jmp/call). Without it every word is
// delivered as a one-word instruction.
module rp_8bit_fetch #(
    parameter int PAW = 11
) (
    input  logic           clk,
    input  logic           rst,
    output logic           bus_req,
    output logic [PAW-1:0] bus_adr,
    input  logic           bus_ack,
    input  logic [15:0]    bus_rdt,
    output logic           ins_vld,
    input  logic           ins_rdy,
    output logic [31:0]    ins_op,
    output logic [PAW-1:0] ins_pc,
    output logic           ins_len,
    input  logic           jmp_vld,
    input  logic [PAW-1:0] jmp_adr,
    input  logic           skp,
    input  logic           hlt
);

    logic [1:0][15:0]    qw_q, qw_d;     // queue words, [0] is the head
    logic [1:0][PAW-1:0] qa_q, qa_d;     // queue word addresses
    logic [1:0]          cnt_q, cnt_d;   // queue occupancy 0..2
    logic [PAW-1:0]      fpc_q, fpc_d;   // next address to fetch
    logic [PAW-1:0]      adr_q, adr_d;   // address of the read in flight
    logic                out_q, out_d;   // read outstanding (drives bus_req)
    logic                drop_q, drop_d; // in-flight read belongs to a stale path
    logic                skip_q, skip_d;

    logic       head_long;
    logic       complete;
    logic       ack;
    logic       push;
    logic       issue;
    logic [1:0] pop_n;
    logic [1:0] cnt_pop;
    logic [1:0] cnt_new;

`ifdef RP_8BIT_FETCH_LONG_EN
    // lds/sts: 1001_00xx_xxxx_0000, jmp/call: 1001_010x_xxxx_11xx
    assign head_long = ((qw_q[0][15:10] == 6'b100100) && (qw_q[0][3:0] == 4'h0)) ||
                       ((qw_q[0][15:9] == 7'b1001010) && (qw_q[0][3:2] == 2'b11));
`else
    assign head_long = 1'b0;
`endif

    assign complete = (cnt_q != 2'd0) && (!head_long || (cnt_q == 2'd2));
    assign ins_vld  = complete && !skip_q;
    assign ins_len  = ins_vld && head_long;
    assign ins_pc   = ins_vld ? qa_q[0] : '0;
    assign ins_op   = ins_vld ? {(head_long ? qw_q[1] : 16'h0000), qw_q[0]} : 32'h0;

    assign bus_req = out_q;
    assign bus_adr = adr_q;

    // A skipped instruction leaves the queue exactly like an accepted one.
    assign pop_n   = (complete && (skip_q || ins_rdy)) ? (head_long ? 2'd2 : 2'd1) : 2'd0;
    assign cnt_pop = cnt_q - pop_n;

    assign ack  = out_q && bus_ack;
    // Data arriving with a redirect, or for a dropped read, is thrown away.
    assign push = ack && !drop_q && !jmp_vld;
    assign cnt_new = cnt_pop + {1'b0, push};

    // The slot is free once the in-flight read (if any) completes this cycle
    // and the queue, after pop and push, still has room.
    assign issue = !hlt && (!out_q || ack) && (jmp_vld || (cnt_new < 2'd2));

    always_comb begin
        qw_d = qw_q;
        qa_d = qa_q;
        if (pop_n == 2'd1) begin
            qw_d[0] = qw_q[1];
            qa_d[0] = qa_q[1];
        end
        if (push) begin
            qw_d[cnt_pop[0]] = bus_rdt;
            qa_d[cnt_pop[0]] = adr_q;
        end
    end

    always_comb begin
        cnt_d  = jmp_vld ? 2'd0 : cnt_new;
        fpc_d  = jmp_vld ? jmp_adr : (fpc_q + {{(PAW-1){1'b0}}, push});
        out_d  = issue || (out_q && !ack);
        adr_d  = issue ? fpc_d : adr_q;
        drop_d = drop_q;
        if (jmp_vld)
            drop_d = out_q && !ack;
        else if (ack)
            drop_d = 1'b0;
        skip_d = skip_q;
        if (jmp_vld)
            skip_d = 1'b0;
        else if (skp)
            skip_d = 1'b1;
        else if (skip_q && complete)
            skip_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qw_q   <= '0;
            qa_q   <= '0;
            cnt_q  <= 2'd0;
            fpc_q  <= '0;
            adr_q  <= '0;
            out_q  <= 1'b0;
            drop_q <= 1'b0;
            skip_q <= 1'b0;
        end else begin
            qw_q   <= qw_d;
            qa_q   <= qa_d;
            cnt_q  <= cnt_d;
            fpc_q  <= fpc_d;
            adr_q  <= adr_d;
            out_q  <= out_d;
            drop_q <= drop_d;
            skip_q <= skip_d;
        end
    end

endmodule

// File: tb/tb_rp_8bit_fetch.sv
// Self-checking bench for rp_8bit_fetch: a PAW=11 instance on a memory model
// with programmable wait states, and a PAW=4 instance on zero-wait memory
// for address wrap. Expected instructions go into a scoreboard queue when a
// fetch is started and are popped as the decoder side accepts them.
module tb_rp_8bit_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance (PAW=11)
    logic        bus_req, bus_ack, ins_vld, ins_rdy, ins_len, jmp_vld;
    logic [10:0] bus_adr, ins_pc, jmp_adr;
    logic [15:0] bus_rdt;
    logic [31:0] ins_op;
    logic        skp = 1'b0, hlt = 1'b0;

    // wrap instance (PAW=4)
    logic        w_req, w_ack, w_vld, w_rdy, w_len, w_jmp;
    logic [3:0]  w_adr, w_pc, w_jadr;
    logic [15:0] w_rdt;
    logic [31:0] w_op;

    logic        rdy = 1'b0, jv = 1'b0, sel = 1'b0;
    logic [10:0] jadr = '0;

    logic [15:0] mem  [2048];
    logic [15:0] mem4 [16];
    int ws = 0, wcnt = 0;

    assign bus_ack = bus_req && (wcnt >= ws);
    assign bus_rdt = mem[bus_adr];
    always @(posedge clk) begin
        if (bus_req && !bus_ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
    end
    assign w_ack = w_req;
    assign w_rdt = mem4[w_adr];

    assign ins_rdy = rdy && !sel;
    assign w_rdy   = rdy && sel;
    assign jmp_vld = jv && !sel;
    assign w_jmp   = jv && sel;
    assign jmp_adr = jadr;
    assign w_jadr  = jadr[3:0];

    logic        m_vld, m_len;
    logic [31:0] m_op;
    logic [10:0] m_pc;
    assign m_vld = sel ? w_vld : ins_vld;
    assign m_len = sel ? w_len : ins_len;
    assign m_op  = sel ? w_op  : ins_op;
    assign m_pc  = sel ? {7'd0, w_pc} : ins_pc;

    rp_8bit_fetch #(.PAW(11)) u_dut (
        .clk(clk), .rst(rst),
        .bus_req(bus_req), .bus_adr(bus_adr), .bus_ack(bus_ack), .bus_rdt(bus_rdt),
        .ins_vld(ins_vld), .ins_rdy(ins_rdy), .ins_op(ins_op), .ins_pc(ins_pc), .ins_len(ins_len),
        .jmp_vld(jmp_vld), .jmp_adr(jmp_adr), .skp(skp), .hlt(hlt)
    );

    rp_8bit_fetch #(.PAW(4)) u_wrap (
        .clk(clk), .rst(rst),
        .bus_req(w_req), .bus_adr(w_adr), .bus_ack(w_ack), .bus_rdt(w_rdt),
        .ins_vld(w_vld), .ins_rdy(w_rdy), .ins_op(w_op), .ins_pc(w_pc), .ins_len(w_len),
        .jmp_vld(w_jmp), .jmp_adr(w_jadr), .skp(1'b0), .hlt(1'b0)
    );

    // fetch addresses issued by the wrap instance
    logic wlog_en = 1'b0;
    int   wlog[$];
    always @(posedge clk) if (wlog_en && w_req) wlog.push_back(int'(w_adr));

    typedef struct {
        logic [31:0] op;
        logic [10:0] pc;
        logic        len;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic        lng;   // two-word when long detect is enabled
    } vec_t;
    vec_t tv[10];

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [31:0] op, input logic [10:0] pc, input logic len);
        exp_t e;
        e.op = op; e.pc = pc; e.len = len;
        exp_q.push_back(e);
    endtask

    // Accept n instructions; entered and left just after a falling edge.
    task automatic accept(input int n, input string name);
        int got;
        exp_t e;
        got = 0;
        rdy = 1'b1;
        for (int cyc = 0; cyc < 80 && got < n; cyc++) begin
            if (m_vld) begin
                got++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL %s: unexpected instruction pc %h op %h", name, m_pc, m_op);
                end else begin
                    e = exp_q.pop_front();
                    chk({name, "_pc"},  {21'd0, m_pc}, {21'd0, e.pc});
                    chk({name, "_op"},  m_op, e.op);
                    chk({name, "_len"}, {31'd0, m_len}, {31'd0, e.len});
                end
            end
            if (got < n) @(negedge clk);
        end
        if (got < n) begin
            checks++; errors++;
            $display("FAIL %s: timeout, got %0d of %0d instructions", name, got, n);
        end
        @(posedge clk);
        #1 rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_jmp(input logic [10:0] a);
        jv = 1'b1;
        jadr = a;
        @(negedge clk);
        jv = 1'b0;
    endtask

    logic long_en;
    logic l;
    int   a;

    initial begin
        tv[0] = '{16'h9100, 16'h1234, 1'b1};  // lds
        tv[1] = '{16'h9200, 16'h1235, 1'b1};  // sts
        tv[2] = '{16'h940C, 16'h1236, 1'b1};  // jmp
        tv[3] = '{16'h940E, 16'h1237, 1'b1};  // call
        tv[4] = '{16'h9101, 16'h1238, 1'b0};  // ld Z+
        tv[5] = '{16'h9508, 16'h1239, 1'b0};  // ret
        tv[6] = '{16'h95FF, 16'h123A, 1'b1};  // call family, high bits set
        tv[7] = '{16'h9300, 16'h123B, 1'b1};  // sts, upper register
        tv[8] = '{16'h9600, 16'h123C, 1'b0};  // adiw
        tv[9] = '{16'h0000, 16'h123D, 1'b0};  // nop
`ifdef RP_8BIT_FETCH_LONG_EN
        long_en = 1'b1;
`else
        long_en = 1'b0;
`endif
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 16; i++) mem4[i] = 16'h0000;
        mem[0] = 16'h0000; mem[1] = 16'hE0F5; mem[2] = 16'h9503;
        mem[4] = 16'h9100; mem[5] = 16'h0123;
        mem[7] = 16'h7777; mem[16'h100] = 16'hABCD;
        mem[10] = 16'h940E; mem[11] = 16'h0055; mem[12] = 16'h1111;
        mem[16'h60] = 16'h2222;
        for (int i = 0; i < 6; i++) mem[16'h80 + i] = 16'h1000 + 16'(i);
        mem4[15] = 16'h940C; mem4[0] = 16'h00AA; mem4[1] = 16'h0BB0;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_adr", {21'd0, bus_adr}, 32'd0);
        chk("rst_vld", {31'd0, ins_vld}, 32'd0);
        chk("rst_op",  ins_op, 32'd0);
        chk("rst_pc",  {21'd0, ins_pc}, 32'd0);
        chk("rst_len", {31'd0, ins_len}, 32'd0);
        rst = 1'b0;                                   // cycle 0
        @(negedge clk);                               // cycle 1
        chk("c1_req", {31'd0, bus_req}, 32'd1);
        chk("c1_adr", {21'd0, bus_adr}, 32'd0);
        chk("c1_vld", {31'd0, ins_vld}, 32'd0);
        @(negedge clk);                               // cycle 2
        chk("c2_vld", {31'd0, ins_vld}, 32'd1);
        exp_push(32'h0000_0000, 11'd0, 1'b0);
        exp_push(32'h0000_E0F5, 11'd1, 1'b0);
        exp_push(32'h0000_9503, 11'd2, 1'b0);
        accept(3, "boot");

        // lds at address 4
        do_jmp(11'd4);
        if (long_en) exp_push(32'h0123_9100, 11'd4, 1'b1);
        else begin
            exp_push(32'h0000_9100, 11'd4, 1'b0);
            exp_push(32'h0000_0123, 11'd5, 1'b0);
        end
        accept(long_en ? 1 : 2, "lds");

        // long-detect table
        for (int i = 0; i < 10; i++) begin
            a = 'h20 + 4 * i;
            mem[a] = tv[i].w0;
            mem[a + 1] = tv[i].w1;
            ws = i % 3;
            l = long_en && tv[i].lng;
            if (l) exp_push({tv[i].w1, tv[i].w0}, 11'(a), 1'b1);
            else begin
                exp_push({16'h0, tv[i].w0}, 11'(a), 1'b0);
                exp_push({16'h0, tv[i].w1}, 11'(a + 1), 1'b0);
            end
            do_jmp(11'(a));
            accept(l ? 1 : 2, "tbl");
        end

        // redirect while a 3-wait read of address 7 is in flight
        ws = 0;
        repeat (4) @(negedge clk);
        ws = 3;
        do_jmp(11'd7);
        chk("j7_req", {31'd0, bus_req}, 32'd1);
        chk("j7_adr", {21'd0, bus_adr}, 32'd7);
        jv = 1'b1; jadr = 11'h100;
        @(negedge clk);
        jv = 1'b0;
        for (int c = 0; c < 10 && !bus_ack; c++) begin
            chk("hold_adr", {20'd0, bus_req, bus_adr}, {20'd0, 1'b1, 11'd7});
            @(negedge clk);
        end
        chk("drop_ack", {21'd0, bus_ack, bus_adr}, {21'd0, 1'b1, 11'd7});
        @(negedge clk);
        chk("redir_adr", {20'd0, bus_req, bus_adr}, {20'd0, 1'b1, 11'h100});
        exp_push(32'h0000_ABCD, 11'h100, 1'b0);
        accept(1, "redir");

        // skip before call at 10
        ws = 0;
        do_jmp(11'd10);
        skp = 1'b1;
        @(negedge clk);
        skp = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("skip_hidden", {31'd0, ins_vld && ins_pc == 11'd10}, 32'd0);
            @(negedge clk);
        end
        if (long_en) exp_push(32'h0000_1111, 11'd12, 1'b0);
        else         exp_push(32'h0000_0055, 11'd11, 1'b0);
        accept(1, "skip");

        // hlt blocks new reads
        hlt = 1'b1;
        do_jmp(11'h60);
        repeat (5) @(negedge clk);
        chk("hlt_req", {31'd0, bus_req}, 32'd0);
        chk("hlt_vld", {31'd0, ins_vld}, 32'd0);
        hlt = 1'b0;
        exp_push(32'h0000_2222, 11'h60, 1'b0);
        accept(1, "hlt");

        // decoder stalled for 10 cycles
        ws = 1;
        do_jmp(11'h80);
        repeat (10) @(negedge clk);
        chk("full_req", {31'd0, bus_req}, 32'd0);
        chk("full_vld", {31'd0, ins_vld}, 32'd1);
        chk("full_pc",  {21'd0, ins_pc}, 32'h80);
        for (int i = 0; i < 5; i++) exp_push({16'h0, 16'h1000 + 16'(i)}, 11'(16'h80 + i), 1'b0);
        accept(5, "stall");

        // PAW=4 wrap from 15
        sel = 1'b1;
        do_jmp(11'd15);
        wlog_en = 1'b1;
        if (long_en) begin
            exp_push(32'h00AA_940C, 11'd15, 1'b1);
            exp_push(32'h0000_0BB0, 11'd1, 1'b0);
        end else begin
            exp_push(32'h0000_940C, 11'd15, 1'b0);
            exp_push(32'h0000_00AA, 11'd0, 1'b0);
            exp_push(32'h0000_0BB0, 11'd1, 1'b0);
        end
        accept(long_en ? 2 : 3, "wrap");
        wlog_en = 1'b0;
        if (wlog.size() < 3) begin
            checks++; errors++;
            $display("FAIL wrap_seq: only %0d fetches logged, need 3", wlog.size());
        end else begin
            chk("wrap_f0", wlog[0], 32'd15);
            chk("wrap_f1", wlog[1], 32'd0);
            chk("wrap_f2", wlog[2], 32'd1);
        end
        sel = 1'b0;

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
